// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, WIDTH RUN cycles per operation.
// start in IDLE/DONE loads operands; start during RUN is ignored; sum/cout/overflow update only on entering DONE.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic             last_bit;
    logic [WIDTH:0]   shifted;

    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
        // New bit enters at the MSB; after WIDTH shifts the partial result is aligned.
        shifted  = {bit_s, part_q};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    part_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                part_d  = shifted[WIDTH:1];
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    // carry_q is the carry into the MSB slice at this point.
                    state_d = DONE;
                    sum_d   = shifted[WIDTH:1];
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 and WIDTH=1 instances, queue scoreboard checked on done.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t prev8 = '0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] full;
        logic [7:0] bn;
        logic [7:0] am;
        exp_t       e;
        am   = (w == 8) ? a : (a & 8'h01);
        bn   = (w == 8) ? (b ^ {8{s}}) : ((b ^ {8{s}}) & 8'h01);
        full = {1'b0, am} + {1'b0, bn} + {8'b0, s};
        if (w == 8) begin
            e.s = full[7:0];
            e.c = full[8];
            e.v = (am[7] == bn[7]) && (full[7] != am[7]);
        end else begin
            e.s = {7'b0, full[0]};
            e.c = full[1];
            e.v = (am[0] == bn[0]) && (full[0] != am[0]);
        end
        return e;
    endfunction

    task automatic pop_check8(input string tag);
        exp_t e;
        if (q8.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = q8.pop_front();
            check({tag, "_sum"}, 64'(sum8), 64'(e.s));
            check({tag, "_cout"}, 64'(cout8), 64'(e.c));
            check({tag, "_ovf"}, 64'(ovf8), 64'(e.v));
            prev8 = e;
        end
    endtask

    // Called at a negedge; poke>0 pulses start with other operands after that many busy cycles.
    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input int poke);
        int n;
        start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 20) begin
            if (n == 3) check({tag, "_hold_run"}, 64'(sum8), 64'(prev8.s));
            n++;
            if (n == poke) begin
                start8 = 1'b1; sub8 = ~s; a8 = ~a; b8 = a;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'(8));
        check({tag, "_done"}, 64'(done8), 64'(1));
        check({tag, "_busy_at_done"}, 64'(busy8), 64'(0));
        pop_check8(tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done8), 64'(0));
        check({tag, "_idle_after"}, 64'(busy8), 64'(0));
    endtask

    task automatic run1(input logic s, input logic a, input logic b);
        exp_t e;
        int   n;
        e = model(1, s, {7'b0, a}, {7'b0, b});
        start1 = 1'b1; sub1 = s; a1 = a; b1 = b;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("w1_busy_cycles", 64'(n), 64'(1));
        check("w1_done", 64'(done1), 64'(1));
        if (q1.size() == 0) begin
            check("w1_sb_empty", 64'(1), 64'(0));
        end else begin
            e = q1.pop_front();
            check($sformatf("w1_sum_s%0d_a%0d_b%0d", s, a, b), 64'(sum1), 64'(e.s[0]));
            check($sformatf("w1_cout_s%0d_a%0d_b%0d", s, a, b), 64'(cout1), 64'(e.c));
            check($sformatf("w1_ovf_s%0d_a%0d_b%0d", s, a, b), 64'(ovf1), 64'(e.v));
        end
        @(negedge clk);
        check("w1_done_one_cycle", 64'(done1), 64'(0));
    endtask

    initial begin
        int         n;
        int         cyc;
        logic       rs;
        logic [7:0] ra, rb;

        #2;
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_done", 64'(done8), 64'(0));
        check("rst_sum", 64'(sum8), 64'(0));
        check("rst_cout", 64'(cout8), 64'(0));
        check("rst_ovf", 64'(ovf8), 64'(0));
        check("rst_busy_w1", 64'(busy1), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // start on the first edge after reset release
        run8("add_0f_01", 1'b0, 8'h0F, 8'h01, '{8'h10, 1'b0, 1'b0}, -1);
        run8("add_ff_01", 1'b0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0}, -1);
        run8("add_7f_01", 1'b0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1}, -1);
        run8("add_80_80", 1'b0, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b1}, -1);
        run8("sub_05_07", 1'b1, 8'h05, 8'h07, '{8'hFE, 1'b0, 1'b0}, -1);
        run8("sub_80_01", 1'b1, 8'h80, 8'h01, '{8'h7F, 1'b1, 1'b1}, -1);
        run8("mid_run_start", 1'b0, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0}, 3);

        for (int i = 0; i < 4; i++) begin
            rs = 1'($urandom_range(1, 0));
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            run8($sformatf("rand%0d", i), rs, ra, rb, model(8, rs, ra, rb), -1);
        end

        // back-to-back: start held high through DONE
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
        q8.push_back('{8'h03, 1'b0, 1'b0});
        @(negedge clk);
        sub8 = 1'b1; a8 = 8'hC8; b8 = 8'h64;
        q8.push_back('{8'h64, 1'b1, 1'b1});
        n = 0;
        while (!done8 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_latency", 64'(n), 64'(8));
        pop_check8("b2b_first");
        @(negedge clk);
        cyc = 1;
        check("b2b_no_idle_busy", 64'(busy8), 64'(1));
        check("b2b_no_idle_done", 64'(done8), 64'(0));
        start8 = 1'b0;
        while (!done8 && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_done_period", 64'(cyc), 64'(9));
        pop_check8("b2b_second");
        @(negedge clk);
        check("b2b_done_one_cycle", 64'(done8), 64'(0));

        // reset during RUN cycle 4
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_run_busy_before", 64'(busy8), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_run_busy", 64'(busy8), 64'(0));
        check("rst_run_done", 64'(done8), 64'(0));
        check("rst_run_sum", 64'(sum8), 64'(0));
        check("rst_run_cout", 64'(cout8), 64'(0));
        check("rst_run_ovf", 64'(ovf8), 64'(0));
        prev8 = '0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        check("rst_run_no_done", 64'(n), 64'(0));
        check("rst_run_sum_after", 64'(sum8), 64'(0));
        run8("after_rst_sub_03_05", 1'b1, 8'h03, 8'h05, '{8'hFE, 1'b0, 1'b0}, -1);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    run1(1'(s), 1'(a), 1'(b));

        check("sb8_drained", 64'(q8.size()), 64'(0));
        check("sb1_drained", 64'(q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
